// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with IDLE/RUN/HALTED control,
// a ready/valid fetch handshake, jump/call/return redirection and
// wrap/range error pulses.
// Optional feature: define PC_SEQ_RAS_EN to build the return-address stack
// (RAS_DEPTH entries). Without it, call behaves as a plain jump, return is
// ignored and o_ras_err is held at 0.
module pc_sequencer #(
  parameter int PC_BITS   = 8,
  parameter int MEM_DEPTH = 24,
  parameter int RAS_DEPTH = 4
) (
  input  logic               i_clk,
  input  logic               i_nrst,
  input  logic               i_start,
  input  logic               i_halt,
  input  logic               i_ready,
  input  logic               i_load,
  input  logic               i_call,
  input  logic               i_ret,
  input  logic [PC_BITS-1:0] i_addr,
  output logic [PC_BITS-1:0] o_pc,
  output logic               o_valid,
  output logic               o_wrap,
  output logic               o_err,
  output logic               o_ras_err
);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  // Last legal address and the depth widened by one bit so that a
  // MEM_DEPTH of 2^PC_BITS is still representable in the range compare.
  localparam logic [PC_BITS-1:0] LAST_PC = PC_BITS'(MEM_DEPTH - 1);
  localparam logic [PC_BITS:0]   DEPTH_X = (PC_BITS+1)'(MEM_DEPTH);

  if (MEM_DEPTH < 2 || MEM_DEPTH > (1 << PC_BITS) || RAS_DEPTH < 1) begin : g_bad_cfg
    $error("pc_sequencer: illegal MEM_DEPTH/RAS_DEPTH for PC_BITS");
  end

  // Target is only usable when it addresses real instruction memory.
  function automatic logic addr_in_range(input logic [PC_BITS-1:0] a);
    return ({1'b0, a} < DEPTH_X);
  endfunction

  // Sequential successor, folding back to 0 after the last legal address.
  function automatic logic [PC_BITS-1:0] seq_next(input logic [PC_BITS-1:0] pc);
    return (pc == LAST_PC) ? '0 : pc + PC_BITS'(1);
  endfunction

  state_t             state, state_nxt;
  logic               accept;
  logic               addr_ok;
  logic               seq_wrap;
  logic [PC_BITS-1:0] seq_pc;
  logic [PC_BITS-1:0] pc_nxt;
  logic               wrap_nxt;
  logic               err_nxt;

  assign o_valid  = (state == RUN);
  assign accept   = o_valid && i_ready;
  assign addr_ok  = addr_in_range(i_addr);
  assign seq_pc   = seq_next(o_pc);
  assign seq_wrap = (o_pc == LAST_PC);

`ifdef PC_SEQ_RAS_EN
  localparam int SP_W  = $clog2(RAS_DEPTH + 1);
  localparam int IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  logic [PC_BITS-1:0] ras_mem [RAS_DEPTH];
  logic [SP_W-1:0]    sp;
  logic [SP_W-1:0]    sp_dec;
  logic [IDX_W-1:0]   wr_idx;
  logic [IDX_W-1:0]   rd_idx;
  logic               ras_full;
  logic               ras_empty;
  logic               push;
  logic               pop;
  logic               ras_err_nxt;

  assign sp_dec    = sp - SP_W'(1);
  assign wr_idx    = sp[IDX_W-1:0];
  assign rd_idx    = sp_dec[IDX_W-1:0];
  assign ras_full  = (sp == SP_W'(RAS_DEPTH));
  assign ras_empty = (sp == '0);

  // Next-PC selection: return > call > jump > sequential, only on an accepted fetch.
  always_comb begin
    pc_nxt      = o_pc;
    wrap_nxt    = 1'b0;
    err_nxt     = 1'b0;
    ras_err_nxt = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    if (accept) begin
      pc_nxt   = seq_pc;
      wrap_nxt = seq_wrap;
      if (i_ret) begin
        if (ras_empty) begin
          ras_err_nxt = 1'b1;
        end else begin
          pop      = 1'b1;
          pc_nxt   = ras_mem[rd_idx];
          wrap_nxt = 1'b0;
        end
      end else if (i_call) begin
        if (!addr_ok) begin
          err_nxt = 1'b1;
        end else begin
          pc_nxt   = i_addr;
          wrap_nxt = 1'b0;
          // A full stack still redirects; the return address is dropped.
          if (ras_full) ras_err_nxt = 1'b1;
          else          push        = 1'b1;
        end
      end else if (i_load) begin
        if (!addr_ok) begin
          err_nxt = 1'b1;
        end else begin
          pc_nxt   = i_addr;
          wrap_nxt = 1'b0;
        end
      end
    end
  end

  // Stack pointer: cleared by reset so the stack is empty after reset.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst)   sp <= '0;
    else if (push) sp <= sp + SP_W'(1);
    else if (pop)  sp <= sp_dec;
  end

  // Stack storage holds only data, so it carries no reset.
  always_ff @(posedge i_clk) begin
    if (push) ras_mem[wr_idx] <= seq_pc;
  end

  // Stack error pulse, aligned with the PC update it belongs to.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) o_ras_err <= 1'b0;
    else         o_ras_err <= ras_err_nxt;
  end
`else
  // Return has no meaning without a stack.
  logic unused_ret;
  assign unused_ret = i_ret;

  // Next-PC selection: call and jump are equivalent, only on an accepted fetch.
  always_comb begin
    pc_nxt   = o_pc;
    wrap_nxt = 1'b0;
    err_nxt  = 1'b0;
    if (accept) begin
      pc_nxt   = seq_pc;
      wrap_nxt = seq_wrap;
      if (i_call || i_load) begin
        if (!addr_ok) begin
          err_nxt = 1'b1;
        end else begin
          pc_nxt   = i_addr;
          wrap_nxt = 1'b0;
        end
      end
    end
  end

  assign o_ras_err = 1'b0;
`endif

  // Control FSM next state; a halt request wins over a simultaneous start.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = RUN;
      RUN:     if (i_halt)  state_nxt = HALTED;
      HALTED:  if (i_start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // State, PC and pulse registers; PC is kept across HALTED for resume.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state  <= IDLE;
      o_pc   <= '0;
      o_wrap <= 1'b0;
      o_err  <= 1'b0;
    end else begin
      state  <= state_nxt;
      o_pc   <= pc_nxt;
      o_wrap <= wrap_nxt;
      o_err  <= err_nxt;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer
// (default parameters: PC_BITS=8, MEM_DEPTH=24, RAS_DEPTH=4).
module tb_pc_sequencer;

  logic       i_clk;
  logic       i_nrst;
  logic       i_start;
  logic       i_halt;
  logic       i_ready;
  logic       i_load;
  logic       i_call;
  logic       i_ret;
  logic [7:0] i_addr;
  logic [7:0] o_pc;
  logic       o_valid;
  logic       o_wrap;
  logic       o_err;
  logic       o_ras_err;

  int n_cmp = 0;
  int n_bad = 0;

  pc_sequencer #(.PC_BITS(8), .MEM_DEPTH(24), .RAS_DEPTH(4)) dut (
    .i_clk    (i_clk),
    .i_nrst   (i_nrst),
    .i_start  (i_start),
    .i_halt   (i_halt),
    .i_ready  (i_ready),
    .i_load   (i_load),
    .i_call   (i_call),
    .i_ret    (i_ret),
    .i_addr   (i_addr),
    .o_pc     (o_pc),
    .o_valid  (o_valid),
    .o_wrap   (o_wrap),
    .o_err    (o_err),
    .o_ras_err(o_ras_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_start = 1'b0; i_halt = 1'b0; i_ready = 1'b0;
    i_load  = 1'b0; i_call = 1'b0; i_ret   = 1'b0;
    i_addr  = 8'd0;
  endtask

  // Reset, then start: leaves the DUT in RUN with o_pc = 0.
  task automatic restart();
    i_nrst = 1'b0;
    clear_inputs();
    #3;
    i_nrst = 1'b1;
    tick();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic advance(input int n);
    i_ready = 1'b1;
    repeat (n) tick();
    i_ready = 1'b0;
  endtask

  task automatic test_reset();
    i_nrst = 1'b0;
    clear_inputs();
    #1;
    n_cmp++; if (o_pc !== 8'd0)     begin n_bad++; $display("FAIL reset_pc: got %0d expected 0", o_pc); end
    n_cmp++; if (o_valid !== 1'b0)  begin n_bad++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
    n_cmp++; if (o_wrap !== 1'b0)   begin n_bad++; $display("FAIL reset_wrap: got %b expected 0", o_wrap); end
    n_cmp++; if (o_err !== 1'b0)    begin n_bad++; $display("FAIL reset_err: got %b expected 0", o_err); end
    n_cmp++; if (o_ras_err !== 1'b0) begin n_bad++; $display("FAIL reset_ras_err: got %b expected 0", o_ras_err); end
    #3;
    i_nrst  = 1'b1;
    i_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL idle_valid: got %b expected 0", o_valid); end
      n_cmp++; if (o_pc !== 8'd0)    begin n_bad++; $display("FAIL idle_pc: got %0d expected 0", o_pc); end
    end
    i_ready = 1'b0;
  endtask

  task automatic test_wrap();
    logic [7:0] exp_pc;
    logic       exp_w;
    restart();
    n_cmp++; if (o_pc !== 8'd0)    begin n_bad++; $display("FAIL start_pc: got %0d expected 0", o_pc); end
    n_cmp++; if (o_valid !== 1'b1) begin n_bad++; $display("FAIL start_valid: got %b expected 1", o_valid); end
    i_ready = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      tick();
      exp_pc = 8'(k % 24);
      exp_w  = (k == 24);
      n_cmp++; if (o_pc !== exp_pc) begin n_bad++; $display("FAIL wrap_pc step %0d: got %0d expected %0d", k, o_pc, exp_pc); end
      n_cmp++; if (o_wrap !== exp_w) begin n_bad++; $display("FAIL wrap_pulse step %0d: got %b expected %b", k, o_wrap, exp_w); end
    end
    i_ready = 1'b0;
  endtask

  task automatic test_stall();
    restart();
    advance(5);
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (o_pc !== 8'd5)    begin n_bad++; $display("FAIL stall_pc: got %0d expected 5", o_pc); end
      n_cmp++; if (o_valid !== 1'b1) begin n_bad++; $display("FAIL stall_valid: got %b expected 1", o_valid); end
    end
    i_ready = 1'b1;
    tick();
    n_cmp++; if (o_pc !== 8'd6) begin n_bad++; $display("FAIL stall_release_pc: got %0d expected 6", o_pc); end
    i_ready = 1'b0;
  endtask

  task automatic test_load();
    restart();
    advance(3);
    i_ready = 1'b1; i_load = 1'b1; i_addr = 8'd17;
    tick();
    n_cmp++; if (o_pc !== 8'd17) begin n_bad++; $display("FAIL load_pc: got %0d expected 17", o_pc); end
    n_cmp++; if (o_err !== 1'b0) begin n_bad++; $display("FAIL load_err: got %b expected 0", o_err); end
    i_addr = 8'd30;
    tick();
    n_cmp++; if (o_pc !== 8'd18) begin n_bad++; $display("FAIL load_oob_pc: got %0d expected 18", o_pc); end
    n_cmp++; if (o_err !== 1'b1) begin n_bad++; $display("FAIL load_oob_err: got %b expected 1", o_err); end
    i_load = 1'b0;
    tick();
    n_cmp++; if (o_pc !== 8'd19) begin n_bad++; $display("FAIL load_after_pc: got %0d expected 19", o_pc); end
    n_cmp++; if (o_err !== 1'b0) begin n_bad++; $display("FAIL err_one_cycle: got %b expected 0", o_err); end
    // Jump while the consumer stalls must be ignored.
    i_ready = 1'b0; i_load = 1'b1; i_addr = 8'd2;
    tick();
    n_cmp++; if (o_pc !== 8'd19) begin n_bad++; $display("FAIL load_no_accept_pc: got %0d expected 19", o_pc); end
    // Highest legal target, then first illegal one from the last address.
    i_ready = 1'b1; i_addr = 8'd23;
    tick();
    n_cmp++; if (o_pc !== 8'd23) begin n_bad++; $display("FAIL load_last_pc: got %0d expected 23", o_pc); end
    i_addr = 8'd24;
    tick();
    n_cmp++; if (o_pc !== 8'd0)   begin n_bad++; $display("FAIL load_depth_pc: got %0d expected 0", o_pc); end
    n_cmp++; if (o_err !== 1'b1)  begin n_bad++; $display("FAIL load_depth_err: got %b expected 1", o_err); end
    n_cmp++; if (o_wrap !== 1'b1) begin n_bad++; $display("FAIL load_depth_wrap: got %b expected 1", o_wrap); end
    i_load = 1'b0;
    tick();
    n_cmp++; if (o_pc !== 8'd1)   begin n_bad++; $display("FAIL load_resume_pc: got %0d expected 1", o_pc); end
    i_ready = 1'b0;
  endtask

  task automatic test_halt();
    restart();
    advance(7);
    i_halt = 1'b1; i_ready = 1'b1;
    tick();
    i_halt = 1'b0;
    n_cmp++; if (o_pc !== 8'd8)    begin n_bad++; $display("FAIL halt_pc: got %0d expected 8", o_pc); end
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL halt_valid: got %b expected 0", o_valid); end
    tick();
    tick();
    n_cmp++; if (o_pc !== 8'd8)    begin n_bad++; $display("FAIL halted_pc: got %0d expected 8", o_pc); end
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL halted_valid: got %b expected 0", o_valid); end
    i_start = 1'b1; i_ready = 1'b0;
    tick();
    i_start = 1'b0;
    n_cmp++; if (o_valid !== 1'b1) begin n_bad++; $display("FAIL resume_valid: got %b expected 1", o_valid); end
    n_cmp++; if (o_pc !== 8'd8)    begin n_bad++; $display("FAIL resume_pc: got %0d expected 8", o_pc); end
    // Start and halt together while running counts as a halt.
    i_start = 1'b1; i_halt = 1'b1;
    tick();
    i_start = 1'b0; i_halt = 1'b0;
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL start_halt_valid: got %b expected 0", o_valid); end
    i_start = 1'b1;
    tick();
    i_start = 1'b0; i_ready = 1'b1;
    tick();
    n_cmp++; if (o_pc !== 8'd9) begin n_bad++; $display("FAIL after_resume_pc: got %0d expected 9", o_pc); end
    i_ready = 1'b0;
  endtask

`ifdef PC_SEQ_RAS_EN
  task automatic test_call_ret();
    logic [7:0] exp_pop [4];
    logic       exp_e;
    exp_pop = '{8'd11, 8'd11, 8'd11, 8'd4};
    restart();
    advance(2);
    i_ready = 1'b1; i_call = 1'b1; i_addr = 8'd10;
    tick();
    n_cmp++; if (o_pc !== 8'd10) begin n_bad++; $display("FAIL call_pc: got %0d expected 10", o_pc); end
    i_call = 1'b0; i_ret = 1'b1;
    tick();
    n_cmp++; if (o_pc !== 8'd3) begin n_bad++; $display("FAIL ret_pc: got %0d expected 3", o_pc); end
    i_ret = 1'b0; i_call = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      exp_e = (k == 5);
      n_cmp++; if (o_pc !== 8'd10) begin n_bad++; $display("FAIL nest_pc call %0d: got %0d expected 10", k, o_pc); end
      n_cmp++; if (o_ras_err !== exp_e) begin n_bad++; $display("FAIL nest_ras_err call %0d: got %b expected %b", k, o_ras_err, exp_e); end
    end
    i_call = 1'b0; i_ret = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++; if (o_pc !== exp_pop[k]) begin n_bad++; $display("FAIL pop_pc %0d: got %0d expected %0d", k, o_pc, exp_pop[k]); end
      n_cmp++; if (o_ras_err !== 1'b0) begin n_bad++; $display("FAIL pop_ras_err %0d: got %b expected 0", k, o_ras_err); end
    end
    tick();
    n_cmp++; if (o_pc !== 8'd5)      begin n_bad++; $display("FAIL empty_ret_pc: got %0d expected 5", o_pc); end
    n_cmp++; if (o_ras_err !== 1'b1) begin n_bad++; $display("FAIL empty_ret_ras_err: got %b expected 1", o_ras_err); end
    i_ret = 1'b0;
    tick();
    n_cmp++; if (o_ras_err !== 1'b0) begin n_bad++; $display("FAIL ras_err_one_cycle: got %b expected 0", o_ras_err); end
    i_ready = 1'b0;
  endtask
`else
  task automatic test_call_ret();
    restart();
    advance(2);
    i_ready = 1'b1; i_call = 1'b1; i_addr = 8'd10;
    tick();
    n_cmp++; if (o_pc !== 8'd10) begin n_bad++; $display("FAIL call_pc: got %0d expected 10", o_pc); end
    i_call = 1'b0; i_ret = 1'b1;
    tick();
    n_cmp++; if (o_pc !== 8'd11)     begin n_bad++; $display("FAIL ret_ignored_pc: got %0d expected 11", o_pc); end
    n_cmp++; if (o_ras_err !== 1'b0) begin n_bad++; $display("FAIL ret_ras_err: got %b expected 0", o_ras_err); end
    i_ret = 1'b0; i_call = 1'b1; i_addr = 8'd30;
    tick();
    n_cmp++; if (o_pc !== 8'd12) begin n_bad++; $display("FAIL call_oob_pc: got %0d expected 12", o_pc); end
    n_cmp++; if (o_err !== 1'b1) begin n_bad++; $display("FAIL call_oob_err: got %b expected 1", o_err); end
    i_call = 1'b0; i_ready = 1'b0;
  endtask
`endif

  task automatic test_async_reset();
    restart();
    advance(12);
    n_cmp++; if (o_pc !== 8'd12) begin n_bad++; $display("FAIL pre_reset_pc: got %0d expected 12", o_pc); end
    #2;
    i_nrst = 1'b0;
    #1;
    n_cmp++; if (o_pc !== 8'd0)    begin n_bad++; $display("FAIL async_reset_pc: got %0d expected 0", o_pc); end
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL async_reset_valid: got %b expected 0", o_valid); end
    #2;
    i_nrst  = 1'b1;
    i_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL post_reset_idle_valid: got %b expected 0", o_valid); end
      n_cmp++; if (o_pc !== 8'd0)    begin n_bad++; $display("FAIL post_reset_idle_pc: got %0d expected 0", o_pc); end
    end
    i_ready = 1'b0; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    n_cmp++; if (o_valid !== 1'b1) begin n_bad++; $display("FAIL post_reset_start_valid: got %b expected 1", o_valid); end
    i_ready = 1'b1;
    tick();
    n_cmp++; if (o_pc !== 8'd1) begin n_bad++; $display("FAIL post_reset_run_pc: got %0d expected 1", o_pc); end
    i_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_stall();
    test_load();
    test_halt();
    test_call_ret();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter PC_BITS, default 8: program counter width in bits.
REQ-002 SHALL have parameter MEM_DEPTH, default 24: number of valid instruction addresses, legal range 2..2^PC_BITS.
REQ-003 SHALL have parameter RAS_DEPTH, default 4: return-address stack entries, used only when PC_SEQ_RAS_EN is defined.
REQ-004 i_clk  input  1  clock; all state changes on its rising edge.
REQ-005 i_nrst  input  1  reset, asynchronous, active-low.
REQ-006 i_start  input  1  leave IDLE or HALTED and enter RUN.
REQ-007 i_halt  input  1  request to leave RUN and enter HALTED.
REQ-008 i_ready  input  1  fetch consumer accepts o_pc this cycle.
REQ-009 i_load  input  1  jump: redirect to i_addr on accepted fetch.
REQ-010 i_call  input  1  call: push return address, redirect to i_addr.
REQ-011 i_ret  input  1  return: redirect to popped address.
REQ-012 i_addr  input  PC_BITS  jump/call target.
REQ-013 o_pc  output  PC_BITS  current fetch address, registered.
REQ-014 o_valid  output  1  o_pc is a valid fetch request.
REQ-015 o_wrap  output  1  one-cycle pulse: sequential increment wrapped to 0.
REQ-016 o_err  output  1  one-cycle pulse: i_addr >= MEM_DEPTH on a taken load/call.
REQ-017 o_ras_err  output  1  one-cycle pulse: stack push-when-full or pop-when-empty.

Function
REQ-018 SHALL implement states IDLE, RUN and HALTED; IDLE->RUN on i_start; RUN->HALTED on i_halt; HALTED->RUN on i_start; all other input combinations hold the current state.
REQ-019 o_valid SHALL be 1 exactly when state is RUN; no output SHALL ever be driven X or Z.
REQ-020 A fetch SHALL be accepted when o_valid=1 and i_ready=1; o_pc SHALL update only on an accepted fetch, one cycle later.
REQ-021 With i_ready=0 in RUN, o_pc and o_valid SHALL hold.
REQ-022 Next-PC priority on an accepted fetch SHALL be i_ret > i_call > i_load > sequential.
REQ-023 Sequential next PC SHALL be o_pc+1, or 0 with o_wrap=1 for one cycle when o_pc==MEM_DEPTH-1.
REQ-024 A taken load or call with i_addr >= MEM_DEPTH SHALL not redirect; it SHALL take the sequential path instead, pulse o_err and skip the push.
REQ-025 Control inputs without an accepted fetch (i_load, i_call, i_ret) SHALL be ignored.
REQ-026 i_halt together with an accepted fetch SHALL complete that advance, then enter HALTED; o_pc SHALL be retained for resume.
REQ-027 i_start and i_halt asserted together in RUN SHALL be treated as a halt.

Reset
REQ-028 Asserting i_nrst low SHALL immediately force o_pc=0, o_valid=0, o_wrap=0, o_err=0, o_ras_err=0, state=IDLE and the stack empty, regardless of the clock, including mid-run.
REQ-029 After i_nrst is released, the block SHALL remain in IDLE until i_start is seen on a rising edge.

Configuration
REQ-030 With macro PC_SEQ_RAS_EN defined, i_call SHALL push the wrapped sequential address and redirect; i_ret SHALL pop into o_pc. A push when full SHALL still redirect, leave the stack unchanged and pulse o_ras_err. A pop when empty SHALL take the sequential path and pulse o_ras_err.
REQ-031 Without PC_SEQ_RAS_EN, there SHALL be no stack storage; i_call SHALL behave exactly as i_load; i_ret SHALL be ignored; o_ras_err SHALL be tied to 0.

Verification
REQ-032 Reset, then i_start, then i_ready=1 for 26 cycles -> o_pc runs 0..23, then 0,1; o_wrap pulses once, on the 23->0 step.
REQ-033 In RUN at o_pc=5 with i_ready=0 for 3 cycles -> o_pc stays 5 and o_valid stays 1; on i_ready=1, o_pc becomes 6.
REQ-034 At o_pc=3: i_load with i_addr=17 -> o_pc becomes 17; i_load with i_addr=30 -> o_pc becomes 18 and o_err pulses.
REQ-035 At o_pc=7: i_halt with i_ready=1 -> o_pc becomes 8, then o_valid=0; i_start two cycles later -> o_valid=1 with o_pc still 8.
REQ-036 With PC_SEQ_RAS_EN, at o_pc=2: i_call to 10, then i_ret at 10 -> o_pc goes 10, then 3; five nested calls -> o_ras_err pulses on the fifth; i_ret on an empty stack -> o_ras_err pulses and o_pc increments.
REQ-037 i_nrst pulsed low between clock edges while o_pc=12 -> o_pc=0 and o_valid=0 immediately; the block stays in IDLE until i_start.
